ibuf_llr_writer: RTL and testbench

Writer side of the combine input buffer.
- Accepts a serial stream of 6-bit LLRs for one combine user.
- Packs 16 LLRs per 96-bit word and writes the words to consecutive buffer addresses from 0.
- The buffer is later read circularly, modulo the E01 size, by the RDM read FSM.
- Pulses a completion flag so the combine controller can issue the read-side process request.

---
 rtl/ibuf_llr_writer.sv | 149 ++++++++++++++
 tb/tb_ibuf_llr_writer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ibuf_llr_writer.sv
`default_nettype none
// ============================================================================
// Module   : ibuf_llr_writer
// Brief    : Packs a serial 6-bit LLR stream into 96-bit combine input-buffer
//            words written to consecutive addresses from 0.
// Revision : 1.0 - initial release
// ============================================================================
module ibuf_llr_writer #(
    parameter int LLR_WIDTH     = 6,
    parameter int LLRS_PER_WORD = 16,
    parameter int ADDR_WIDTH    = 16,
    parameter int E_WIDTH       = 14
) (
    input  logic                                 i_core_clk,
    input  logic                                 i_rx_rst,
    input  logic                                 i_rx_fsm_rst,
    input  logic [E_WIDTH-1:0]                   i_Current_Combine_E01_Size,
    input  logic                                 i_Write_Start,
    input  logic                                 i_LLR_Valid,
    input  logic [LLR_WIDTH-1:0]                 i_LLR_Data,
    output logic                                 o_LLR_Ready,
    output logic                                 o_Input_Buffer_Wr_En,
    output logic [ADDR_WIDTH-1:0]                o_Input_Buffer_Wr_Addr,
    output logic [LLR_WIDTH*LLRS_PER_WORD-1:0]   o_Input_Buffer_Wr_Data,
    output logic                                 o_Write_Busy,
    output logic                                 o_Write_Comp
);

    localparam int WORD_WIDTH = LLR_WIDTH * LLRS_PER_WORD;
    localparam int LANE_WIDTH = $clog2(LLRS_PER_WORD);
    localparam logic [LANE_WIDTH-1:0] LAST_LANE = LANE_WIDTH'(LLRS_PER_WORD - 1);

    typedef enum logic [3:0] {
        ST_IDLE    = 4'b0001,
        ST_LOAD    = 4'b0010,
        ST_COLLECT = 4'b0100,
        ST_DONE    = 4'b1000
    } state_t;

    state_t                  state_q;
    logic [E_WIDTH-1:0]      e_last_q;
    logic [E_WIDTH-1:0]      cnt_q;
    logic [LANE_WIDTH-1:0]   lane_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [WORD_WIDTH-1:0]   pack_q;
    logic [WORD_WIDTH-1:0]   pack_d;
    logic                    ready_q;
    logic                    wr_en_q;
    logic [ADDR_WIDTH-1:0]   wr_addr_q;
    logic [WORD_WIDTH-1:0]   wr_data_q;
    logic                    busy_q;
    logic                    comp_q;

    logic w_rst;
    logic w_accept;
    logic w_last_llr;
    logic w_word_full;

    // Both resets have identical effect on this block.
    assign w_rst       = i_rx_rst | i_rx_fsm_rst;
    assign w_accept    = (state_q == ST_COLLECT) & ready_q & i_LLR_Valid;
    assign w_last_llr  = (cnt_q == e_last_q);
    assign w_word_full = (lane_q == LAST_LANE);

    // Pack register with the incoming LLR merged into the current lane.
    always_comb begin
        pack_d = pack_q;
        pack_d[lane_q*LLR_WIDTH +: LLR_WIDTH] = i_LLR_Data;
    end

    always_ff @(posedge i_core_clk or posedge w_rst) begin
        if (w_rst) begin
            state_q   <= ST_IDLE;
            e_last_q  <= '0;
            cnt_q     <= '0;
            lane_q    <= '0;
            addr_q    <= '0;
            pack_q    <= '0;
            ready_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            comp_q    <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            comp_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b0;
                    if (i_Write_Start) begin
                        busy_q  <= 1'b1;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    e_last_q <= i_Current_Combine_E01_Size;
                    cnt_q    <= '0;
                    lane_q   <= '0;
                    addr_q   <= '0;
                    pack_q   <= '0;
                    ready_q  <= 1'b1;
                    state_q  <= ST_COLLECT;
                end
                ST_COLLECT: begin
                    if (w_accept) begin
                        cnt_q <= cnt_q + E_WIDTH'(1);
                        if (w_word_full || w_last_llr) begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= addr_q;
                            wr_data_q <= pack_d;
                            addr_q    <= addr_q + ADDR_WIDTH'(1);
                            lane_q    <= '0;
                            pack_q    <= '0;
                        end else begin
                            lane_q <= lane_q + LANE_WIDTH'(1);
                            pack_q <= pack_d;
                        end
                        // DONE coincides with the final word write.
                        if (w_last_llr) begin
                            ready_q <= 1'b0;
                            comp_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_LLR_Ready            = ready_q;
    assign o_Input_Buffer_Wr_En   = wr_en_q;
    assign o_Input_Buffer_Wr_Addr = wr_addr_q;
    assign o_Input_Buffer_Wr_Data = wr_data_q;
    assign o_Write_Busy           = busy_q;
    assign o_Write_Comp           = comp_q;

endmodule
`default_nettype wire

// File: tb/tb_ibuf_llr_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ibuf_llr_writer
// Brief    : Directed, table-driven self-checking bench for ibuf_llr_writer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ibuf_llr_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fsm_rst = 1'b0;
    logic [13:0] e01 = '0;
    logic        start = 1'b0;
    logic        valid = 1'b0;
    logic [5:0]  data = '0;
    logic        ready, wr_en, busy, comp;
    logic [15:0] wr_addr;
    logic [95:0] wr_data;

    always #5 clk = ~clk;

    ibuf_llr_writer dut (
        .i_core_clk                 (clk),
        .i_rx_rst                   (rst),
        .i_rx_fsm_rst               (fsm_rst),
        .i_Current_Combine_E01_Size (e01),
        .i_Write_Start              (start),
        .i_LLR_Valid                (valid),
        .i_LLR_Data                 (data),
        .o_LLR_Ready                (ready),
        .o_Input_Buffer_Wr_En       (wr_en),
        .o_Input_Buffer_Wr_Addr     (wr_addr),
        .o_Input_Buffer_Wr_Data     (wr_data),
        .o_Write_Busy               (busy),
        .o_Write_Comp               (comp)
    );

    localparam logic [95:0] W0   = 96'h3CE34C_2CA248_1C6144_0C2040;
    localparam logic [95:0] W1   = 96'h7DE75C_6DA658_5D6554_4D2450;
    localparam logic [95:0] W2   = 96'hBEEB6C_AEAA68_9E6964_8E2860;
    localparam logic [95:0] ONES = {96{1'b1}};

    typedef struct {
        int          e01;
        int          pat;
        bit          gaps;
        int          mid;
        int          nwords;
        logic [95:0] w0;
        logic [95:0] wlast;
    } vec_t;

    int n_pass = 0;
    int n_total = 0;

    logic [95:0] log_data[$];
    int          log_addr[$];
    int          comp_n = 0;
    int          comp_hit = 0;

    always @(negedge clk) begin
        if (wr_en) begin
            log_data.push_back(wr_data);
            log_addr.push_back(int'(wr_addr));
        end
        if (comp) begin
            comp_n++;
            if (wr_en) comp_hit++;
        end
    end

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [5:0] llr_val(input int pat, input int k);
        case (pat)
            0:       return 6'(k % 64);
            1:       return 6'h3F;
            default: return 6'h2A;
        endcase
    endfunction

    function automatic logic [95:0] model_word(input int e, input int pat, input int w);
        logic [95:0] r = '0;
        for (int i = 0; i < 16; i++) begin
            if (w*16 + i <= e) r[i*6 +: 6] = llr_val(pat, w*16 + i);
        end
        return r;
    endfunction

    // Starts a job and feeds LLRs; returns at #1 after the final accepting edge.
    task automatic run_job(input int e, input int pat, input bit gaps, input int mid,
                           input int abort_at, output int accepted);
        int k = 0;
        int budget = 0;
        bit gap_phase = 1'b0;
        bit ready_bad = 1'b0;
        bit acc;
        log_data.delete();
        log_addr.delete();
        comp_n = 0;
        comp_hit = 0;
        e01 = 14'(e);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_in_load", busy, 1);
        chk("ready_in_load", ready, 0);
        while (k <= e && budget < 4000) begin
            budget++;
            if (abort_at > 0 && k == abort_at) break;
            if (gaps && gap_phase) begin
                valid = 1'b0;
                if (k > 0 && ready !== 1'b1) ready_bad = 1'b1;
            end else begin
                valid = 1'b1;
                data  = llr_val(pat, k);
            end
            acc = valid & ready;
            if (mid > 0 && k == mid) begin
                start = 1'b1;
                e01   = 14'(e + 100);
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (acc) k++;
            if (gaps) gap_phase = ~gap_phase;
        end
        valid = 1'b0;
        accepted = k;
        if (budget >= 4000) chk("feed_timeout", 1, 0);
        if (gaps) chk("ready_through_gaps", ready_bad, 0);
    endtask

    task automatic post_checks(input vec_t v);
        chk("wr_en_at_done", wr_en, 1);
        chk("comp_at_done", comp, 1);
        chk("ready_at_done", ready, 0);
        @(posedge clk); #1;
        chk("busy_after_done", busy, 0);
        chk("comp_one_cycle", comp, 0);
        valid = 1'b1;
        data  = 6'h15;
        repeat (3) @(posedge clk);
        #1;
        valid = 1'b0;
        @(negedge clk); #1;
        chk("num_writes", log_data.size(), v.nwords);
        for (int i = 0; i < log_data.size(); i++) begin
            chk("wr_addr_seq", log_addr[i], i);
            chk("wr_data_model", log_data[i], model_word(v.e01, v.pat, i));
        end
        if (log_data.size() > 0) begin
            chk("word0_data", log_data[0], v.w0);
            chk("last_word_data", log_data[log_data.size()-1], v.wlast);
        end
        chk("comp_count", comp_n, 1);
        chk("comp_with_last_write", comp_hit, 1);
    endtask

    initial begin
        vec_t vecs[6];
        vec_t v;
        int   acc;
        vecs[0] = '{e01: 31, pat: 0, gaps: 1'b0, mid: 0, nwords: 2, w0: W0, wlast: W1};
        vecs[1] = '{e01: 20, pat: 1, gaps: 1'b0, mid: 0, nwords: 2, w0: ONES, wlast: 96'h3FFFFFFF};
        vecs[2] = '{e01: 15, pat: 0, gaps: 1'b1, mid: 0, nwords: 1, w0: W0, wlast: W0};
        vecs[3] = '{e01: 0,  pat: 2, gaps: 1'b0, mid: 0, nwords: 1, w0: 96'h2A, wlast: 96'h2A};
        vecs[4] = '{e01: 31, pat: 0, gaps: 1'b0, mid: 5, nwords: 2, w0: W0, wlast: W1};
        vecs[5] = '{e01: 47, pat: 0, gaps: 1'b1, mid: 0, nwords: 3, w0: W0, wlast: W2};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_comp", comp, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_busy", busy, 0);

        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            run_job(v.e01, v.pat, v.gaps, v.mid, 0, acc);
            chk("llrs_accepted", acc, v.e01 + 1);
            post_checks(v);
        end

        // Abort a job with the FSM reset after 10 LLRs, then run a clean job.
        run_job(31, 0, 1'b0, 0, 10, acc);
        chk("abort_accepted", acc, 10);
        fsm_rst = 1'b1;
        #1;
        chk("abort_ready", ready, 0);
        chk("abort_busy", busy, 0);
        chk("abort_wr_en", wr_en, 0);
        @(posedge clk); #1;
        fsm_rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("abort_no_write", log_data.size(), 0);
        chk("abort_no_comp", comp_n, 0);
        v = '{e01: 15, pat: 0, gaps: 1'b0, mid: 0, nwords: 1, w0: W0, wlast: W0};
        run_job(v.e01, v.pat, v.gaps, v.mid, 0, acc);
        chk("post_abort_accepted", acc, 16);
        post_checks(v);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
